sram_matrix_loader: RTL

Sequencer directly downstream of the initialized matrix SRAM. On a start pulse it reads two DIM×DIM matrices, A then B, from consecutive SRAM addresses. It accounts for the SRAM's one-cycle registered read latency and assembles both matrices into flat parallel registers for the multiplier datapath. A one-cycle `done` pulse marks both matrices valid.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/sram_matrix_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared FSM states, matrix sizes and element packing for the matmul slice
package matmul_pkg;

  localparam int MAT_DIM = 4;
  localparam int ELEMS   = MAT_DIM * MAT_DIM;
  localparam int TOTAL   = 2 * ELEMS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Flat element index of (r,c) inside a packed row-major matrix vector.
  function automatic int pack_idx(input int r, input int c);
    return r * MAT_DIM + c;
  endfunction

endpackage

// File: rtl/sram_matrix_loader.sv
// rtl/sram_matrix_loader.sv - reads matrices A and B from the matrix SRAM into flat registers
// Issues 2*DIM*DIM consecutive reads, then pulses done once the last element has landed.
module sram_matrix_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int DIM        = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  output logic                             busy,
  output logic                             done,
  output logic                             sram_en,
  output logic                             sram_we,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  input  logic [DATA_WIDTH-1:0]            sram_data,
  output logic [DIM*DIM*DATA_WIDTH-1:0]    mat_a,
  output logic [DIM*DIM*DATA_WIDTH-1:0]    mat_b
);

  localparam int N_ELEMS = DIM * DIM;
  localparam int N_TOTAL = 2 * N_ELEMS;
  localparam int CW      = $clog2(N_TOTAL) + 1;
  localparam int MW      = N_ELEMS * DATA_WIDTH;

  state_t                  state_q, state_d;
  logic [CW-1:0]           k_q, k_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sram_en_q, sram_en_d;
  logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [MW-1:0]           mat_a_q, mat_a_d;
  logic [MW-1:0]           mat_b_q, mat_b_d;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    base_d      = base_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sram_en_d   = sram_en_q;
    sram_addr_d = sram_addr_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    // SRAM data arrives one cycle after its address, so the issue index is delayed to match.
    valid_d     = sram_en_q;
    idx_d       = k_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = READ;
          base_d      = base_addr;
          k_d         = '0;
          busy_d      = 1'b1;
          sram_en_d   = 1'b1;
          sram_addr_d = base_addr;
        end
      end
      READ: begin
        if (k_q == CW'(N_TOTAL - 1)) begin
          state_d   = DRAIN;
          sram_en_d = 1'b0;
        end else begin
          k_d         = k_q + CW'(1);
          sram_addr_d = base_q + ADDR_WIDTH'(k_q + CW'(1));
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int i = 0; i < N_ELEMS; i++) begin
      if (valid_q && (idx_q == CW'(i))) begin
        mat_a_d[i*DATA_WIDTH +: DATA_WIDTH] = sram_data;
      end
      if (valid_q && (idx_q == CW'(N_ELEMS + i))) begin
        mat_b_d[i*DATA_WIDTH +: DATA_WIDTH] = sram_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sram_en_q   <= 1'b0;
      sram_addr_q <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      base_q      <= base_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sram_en_q   <= sram_en_d;
      sram_addr_q <= sram_addr_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sram_en   = sram_en_q;
  assign sram_we   = 1'b0;
  assign sram_addr = sram_addr_q;
  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;

endmodule
